// File: rtl/rs_pkg.sv
// Shared definitions for the RS(15,11) decode sequencer: symbol geometry,
// counter widths and the backend state encoding.
package rs_pkg;

    localparam int SYM_W     = 4;
    localparam int N_SYM     = 15;
    localparam int SYM_CNT_W = 4;
    localparam int FRAME_W   = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } be_state_e;

endpackage

// File: rtl/rs_symbol_counter.sv
// Position of the incoming symbol within its codeword; wraps after the last
// symbol and flags the first/last positions for the sequencer.
module rs_symbol_counter
    import rs_pkg::*;
#(
    parameter int N_SYM = rs_pkg::N_SYM
) (
    input  logic clk,
    input  logic rst_n,
    input  logic advance_i,
    output logic first_o,
    output logic last_o
);

    localparam logic [SYM_CNT_W-1:0] CNT_LAST = SYM_CNT_W'(N_SYM - 1);

    logic [SYM_CNT_W-1:0] cnt_q;
    logic [SYM_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (advance_i) begin
            cnt_d = last_o ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign first_o = (cnt_q == '0);
    assign last_o  = (cnt_q == CNT_LAST);

endmodule

// File: rtl/rs_decode_sequencer.sv
// Control sequencer for an RS(15,11) decoder: steers the syndrome stage, kicks
// the Euclid solver under a watchdog, then drains one corrected codeword.
module rs_decode_sequencer
    import rs_pkg::*;
#(
    parameter int N_SYM          = rs_pkg::N_SYM,
    parameter int EUCLID_TIMEOUT = 63
) (
    input  logic               CLK,
    input  logic               RESET_N,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               syn_en,
    output logic               syn_clear,
    output logic               syn_capture,
    output logic               euclid_start,
    input  logic               euclid_finished,
    output logic               errpos_control,
    output logic               out_valid,
    output logic               out_sof,
    output logic               out_eof,
    output logic               timeout_err,
    output logic [FRAME_W-1:0] frames_in,
    output logic [FRAME_W-1:0] frames_out
);

    localparam int WD_W = $clog2(EUCLID_TIMEOUT + 1);
    // Abort is decided on the cycle the watchdog would step onto EUCLID_TIMEOUT.
    localparam logic [WD_W-1:0]      WD_LAST    = WD_W'(EUCLID_TIMEOUT - 1);
    localparam logic [SYM_CNT_W-1:0] DRAIN_LAST = SYM_CNT_W'(N_SYM - 1);

    be_state_e            state_q, state_d;
    logic [WD_W-1:0]      wd_q, wd_d;
    logic [SYM_CNT_W-1:0] dcnt_q, dcnt_d;
    logic [FRAME_W-1:0]   frames_in_q, frames_in_d;
    logic [FRAME_W-1:0]   frames_out_q, frames_out_d;
    logic                 euclid_start_q, euclid_start_d;
    logic                 out_valid_q, out_valid_d;
    logic                 out_sof_q, out_sof_d;
    logic                 out_eof_q, out_eof_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 sym_first, sym_last, transfer;

    rs_symbol_counter #(
        .N_SYM(N_SYM)
    ) u_sym_cnt (
        .clk      (CLK),
        .rst_n    (RESET_N),
        .advance_i(transfer),
        .first_o  (sym_first),
        .last_o   (sym_last)
    );

    // Only the final symbol is held back; earlier symbols overlap the backend.
    assign in_ready    = !(sym_last && (state_q != IDLE));
    assign transfer    = in_valid && in_ready;
    assign syn_en      = transfer;
    assign syn_clear   = transfer && sym_first;
    assign syn_capture = transfer && sym_last;

    // NOTE: every signal assigned in a combinational block gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        dcnt_d  = dcnt_q;
        unique case (state_q)
            IDLE: begin
                if (syn_capture) state_d = START;
            end
            START: begin
                state_d = RUN;
                wd_d    = '0;
            end
            RUN: begin
                if (euclid_finished) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end else if (wd_q == WD_LAST) begin
                    state_d = IDLE;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            DRAIN: begin
                if (dcnt_q == DRAIN_LAST) state_d = IDLE;
                else                      dcnt_d  = dcnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from next state so their flops line up with state_q.
    always_comb begin
        euclid_start_d = (state_d == START);
        out_valid_d    = (state_d == DRAIN);
        out_sof_d      = (state_d == DRAIN) && (dcnt_d == '0);
        out_eof_d      = (state_d == DRAIN) && (dcnt_d == DRAIN_LAST);
        timeout_err_d  = (state_q == RUN) && (state_d == IDLE);
        frames_in_d    = frames_in_q + FRAME_W'(syn_capture);
        frames_out_d   = frames_out_q + FRAME_W'(out_eof_d);
    end

    // NOTE: every flop here, counters and output pulses alike, takes the async
    // reset so a partially sequenced codeword cannot leak out after reset.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q        <= IDLE;
            wd_q           <= '0;
            dcnt_q         <= '0;
            frames_in_q    <= '0;
            frames_out_q   <= '0;
            euclid_start_q <= 1'b0;
            out_valid_q    <= 1'b0;
            out_sof_q      <= 1'b0;
            out_eof_q      <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            wd_q           <= wd_d;
            dcnt_q         <= dcnt_d;
            frames_in_q    <= frames_in_d;
            frames_out_q   <= frames_out_d;
            euclid_start_q <= euclid_start_d;
            out_valid_q    <= out_valid_d;
            out_sof_q      <= out_sof_d;
            out_eof_q      <= out_eof_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign euclid_start   = euclid_start_q;
    assign errpos_control = out_valid_q;
    assign out_valid      = out_valid_q;
    assign out_sof        = out_sof_q;
    assign out_eof        = out_eof_q;
    assign timeout_err    = timeout_err_q;
    assign frames_in      = frames_in_q;
    assign frames_out     = frames_out_q;

endmodule

// File: tb/tb_rs_decode_sequencer.sv
// Directed bench for rs_decode_sequencer: streaming, back-pressure, watchdog,
// reset discard and frame counter wrap, with hand-derived cycle numbers.
module tb_rs_decode_sequencer;

    logic       CLK;
    logic       RESET_N;
    logic       in_valid;
    logic       in_ready;
    logic       syn_en;
    logic       syn_clear;
    logic       syn_capture;
    logic       euclid_start;
    logic       euclid_finished;
    logic       errpos_control;
    logic       out_valid;
    logic       out_sof;
    logic       out_eof;
    logic       timeout_err;
    logic [7:0] frames_in;
    logic [7:0] frames_out;

    rs_decode_sequencer #(
        .N_SYM         (15),
        .EUCLID_TIMEOUT(63)
    ) dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .syn_en         (syn_en),
        .syn_clear      (syn_clear),
        .syn_capture    (syn_capture),
        .euclid_start   (euclid_start),
        .euclid_finished(euclid_finished),
        .errpos_control (errpos_control),
        .out_valid      (out_valid),
        .out_sof        (out_sof),
        .out_eof        (out_eof),
        .timeout_err    (timeout_err),
        .frames_in      (frames_in),
        .frames_out     (frames_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Euclid stand-in: pulses euclid_finished fin_delay cycles after euclid_start.
    int fin_delay = 0;
    int fin_at    = -1;
    bit fin_force = 1'b0;

    // Event monitor, sampled mid-cycle; tests read it as before/after deltas.
    int cnt_start = 0, cnt_sof = 0, cnt_eof = 0, cnt_cap = 0, cnt_tmo = 0;
    int cnt_valid = 0, cnt_xfer = 0, cnt_stall = 0, cnt_clear = 0;
    int mis_en = 0, mis_ep = 0;
    int start_hist[8], sof_hist[8], eof_hist[8], cap_hist[8], tmo_hist[8];

    always @(negedge CLK) begin
        if (euclid_start) begin start_hist[cnt_start % 8] = cyc; cnt_start++; end
        if (out_sof)      begin sof_hist[cnt_sof % 8]     = cyc; cnt_sof++;   end
        if (out_eof)      begin eof_hist[cnt_eof % 8]     = cyc; cnt_eof++;   end
        if (syn_capture)  begin cap_hist[cnt_cap % 8]     = cyc; cnt_cap++;   end
        if (timeout_err)  begin tmo_hist[cnt_tmo % 8]     = cyc; cnt_tmo++;   end
        if (out_valid)              cnt_valid++;
        if (in_valid && in_ready)   cnt_xfer++;
        if (in_valid && !in_ready)  cnt_stall++;
        if (syn_clear)              cnt_clear++;
        if (syn_en != (in_valid && in_ready)) mis_en++;
        if (errpos_control != out_valid)      mis_ep++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
        cyc++;
        if (euclid_start && fin_delay > 0) fin_at = cyc + fin_delay;
        euclid_finished = fin_force || (cyc == fin_at);
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    // Holds in_valid high until n symbols are accepted, bounded by a cycle budget.
    task automatic send(input int n);
        int sent  = 0;
        int guard = 0;
        in_valid = 1'b1;
        while (sent < n && guard < n * 4 + 200) begin
            #1;
            if (in_ready) sent++;
            cycle();
            guard++;
        end
        in_valid = 1'b0;
        check("send_done", sent, n);
    endtask

    task automatic pulse_reset();
        RESET_N = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_errpos", int'(errpos_control), 0);
        check("rst_frames_in", int'(frames_in), 0);
        check("rst_frames_out", int'(frames_out), 0);
        check("rst_in_ready", int'(in_ready), 1);
        idle(2);
        RESET_N = 1'b1;
        idle(1);
    endtask

    int c0, bs, bsof, beof, bcap, bstall, bxfer, bvalid, btmo, bclear;

    task automatic snap();
        bs = cnt_start; bsof = cnt_sof; beof = cnt_eof; bcap = cnt_cap;
        bstall = cnt_stall; bxfer = cnt_xfer; bvalid = cnt_valid;
        btmo = cnt_tmo; bclear = cnt_clear;
    endtask

    initial begin
        RESET_N         = 1'b0;
        in_valid        = 1'b0;
        euclid_finished = 1'b0;
        idle(3);
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_euclid_start", int'(euclid_start), 0);
        RESET_N = 1'b1;
        idle(1);
        check("post_reset_in_ready", int'(in_ready), 1);
        check("post_reset_frames_in", int'(frames_in), 0);
        check("post_reset_frames_out", int'(frames_out), 0);
        check("post_reset_timeout", int'(timeout_err), 0);

        // Two back-to-back codewords, solver done 20 cycles after each start.
        fin_delay = 20;
        snap();
        c0 = cyc;
        send(30);
        idle(60);
        check("bb_start_count", cnt_start - bs, 2);
        check("bb_start0_cyc", start_hist[bs % 8], c0 + 15);
        check("bb_start1_cyc", start_hist[(bs + 1) % 8], c0 + 52);
        check("bb_cap0_cyc", cap_hist[bcap % 8], c0 + 14);
        check("bb_cap1_cyc", cap_hist[(bcap + 1) % 8], c0 + 51);
        check("bb_sof0_cyc", sof_hist[bsof % 8], c0 + 36);
        check("bb_eof0_cyc", eof_hist[beof % 8], c0 + 50);
        check("bb_eof1_cyc", eof_hist[(beof + 1) % 8], c0 + 87);
        check("bb_valid_cycles", cnt_valid - bvalid, 30);
        check("bb_stall_cycles", cnt_stall - bstall, 22);
        check("bb_transfers", cnt_xfer - bxfer, 30);
        check("bb_syn_clear", cnt_clear - bclear, 2);
        check("bb_timeouts", cnt_tmo - btmo, 0);
        check("bb_frames_in", int'(frames_in), 2);
        check("bb_frames_out", int'(frames_out), 2);

        // Solver never answers: watchdog abort 63 cycles after RUN entry.
        fin_delay = 0;
        snap();
        c0 = cyc;
        send(15);
        idle(100);
        check("tmo_count", cnt_tmo - btmo, 1);
        check("tmo_cyc", tmo_hist[btmo % 8], c0 + 79);
        check("tmo_valid_cycles", cnt_valid - bvalid, 0);
        check("tmo_frames_in", int'(frames_in), 3);
        check("tmo_frames_out", int'(frames_out), 2);
        check("tmo_in_ready", int'(in_ready), 1);

        // Solver answers on the very cycle the watchdog would abort.
        fin_delay = 63;
        snap();
        c0 = cyc;
        send(15);
        idle(100);
        check("edge_tmo_count", cnt_tmo - btmo, 0);
        check("edge_sof_cyc", sof_hist[bsof % 8], c0 + 79);
        check("edge_eof_cyc", eof_hist[beof % 8], c0 + 93);
        check("edge_frames_out", int'(frames_out), 3);

        // Stray euclid_finished while idle must not start a drain.
        fin_delay = 0;
        snap();
        fin_force = 1'b1;
        idle(5);
        fin_force = 1'b0;
        idle(20);
        check("stray_fin_valid", cnt_valid - bvalid, 0);
        check("stray_fin_start", cnt_start - bs, 0);
        check("stray_fin_frames_out", int'(frames_out), 3);

        // Reset at sym_cnt 7, then reset in DRAIN cycle 5, then a clean codeword.
        send(7);
        #2;
        pulse_reset();
        fin_delay = 5;
        snap();
        c0 = cyc;
        send(15);
        idle(11);
        #2;
        check("drain5_valid", int'(out_valid), 1);
        check("drain5_sof_cyc", sof_hist[bsof % 8], c0 + 21);
        check("drain5_syn_clear", cnt_clear - bclear, 1);
        pulse_reset();
        snap();
        idle(30);
        check("discard_no_eof", cnt_eof - beof, 0);
        check("discard_no_valid", cnt_valid - bvalid, 0);
        c0 = cyc;
        send(15);
        idle(40);
        check("recover_sof_cyc", sof_hist[bsof % 8], c0 + 21);
        check("recover_eof_cyc", eof_hist[beof % 8], c0 + 35);
        check("recover_frames_in", int'(frames_in), 1);
        check("recover_frames_out", int'(frames_out), 1);

        // 256 codewords from a clean reset: both frame counters wrap to 0.
        pulse_reset();
        fin_delay = 1;
        send(255 * 15);
        idle(40);
        check("wrap_frames_in_255", int'(frames_in), 255);
        check("wrap_frames_out_255", int'(frames_out), 255);
        send(15);
        idle(40);
        check("wrap_frames_in_0", int'(frames_in), 0);
        check("wrap_frames_out_0", int'(frames_out), 0);

        check("syn_en_vs_transfer", mis_en, 0);
        check("errpos_vs_out_valid", mis_ep, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
